// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - shared iterative binary-to-BCD converter with round-robin scheduler
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[CH]            per-channel conversion request (level)
//   value[8*CH]        packed 8-bit operands, channel i at [8*i+7:8*i]
//   grant[CH]          one-hot pulse: that channel's value was captured
//   busy               conversion in progress
//   out_valid          pulse: out_ch/hundreds/tens/ones updated
//   out_ch             channel of the current result
//   hundreds/tens/ones BCD digits of the current result
//   rd_sel, rd_bcd     combinational read of the per-channel result bank
module bcd_conv_sched #(
    parameter int CH   = 4,
    parameter int CH_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     req,
    input  logic [8*CH-1:0]   value,
    output logic [CH-1:0]     grant,
    output logic              busy,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [11:0]       rd_bcd
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [19:0]       sreg;
    logic [19:0]       sreg_step;
    logic [3:0]        cnt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   cur_ch;
    logic              win_found;
    logic [CH_W-1:0]   win_idx;
    logic [7:0]        win_val;
    logic [11:0]       bank [CH];

    // One double-dabble step: bits [19:8] hold three BCD digits, [7:0] the
    // remaining binary. Each digit is corrected independently before the shift.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8] >= 4'd5)
            t[11:8] = t[11:8] + 4'd3;
        if (t[15:12] >= 4'd5)
            t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5)
            t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    assign sreg_step = dd_step(sreg);

    // Round-robin pick: scan from the channel after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_val   = '0;
        for (int k = 1; k <= CH; k++) begin
            if (!win_found && req[(int'(ptr) + k) % CH]) begin
                win_found = 1'b1;
                win_idx   = CH_W'((int'(ptr) + k) % CH);
                win_val   = value[8 * ((int'(ptr) + k) % CH) +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_found) state_nxt = CONV;
            CONV: if (cnt == 4'd1) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
            sreg      <= '0;
            cnt       <= '0;
            ptr       <= CH_W'(CH - 1);
            cur_ch    <= '0;
            for (int i = 0; i < CH; i++)
                bank[i] <= '0;
        end else begin
            grant     <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant  <= CH'(1) << win_idx;
                        ptr    <= win_idx;
                        cur_ch <= win_idx;
                        sreg   <= {12'd0, win_val};
                        cnt    <= 4'd8;
                        busy   <= 1'b1;
                    end
                end
                CONV: begin
                    sreg <= sreg_step;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hundreds     <= sreg_step[19:16];
                        tens         <= sreg_step[15:12];
                        ones         <= sreg_step[11:8];
                        out_ch       <= cur_ch;
                        bank[cur_ch] <= sreg_step[19:8];
                        out_valid    <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_bcd = 12'h000;
        for (int i = 0; i < CH; i++) begin
            if (rd_sel == CH_W'(i))
                rd_bcd = bank[i];
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - scoreboard testbench for bcd_conv_sched
module tb_bcd_conv_sched;

    localparam int CH   = 4;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     req = '0;
    logic [8*CH-1:0]   value = '0;
    logic [CH-1:0]     grant;
    logic              busy;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [3:0]        hundreds;
    logic [3:0]        tens;
    logic [3:0]        ones;
    logic [CH_W-1:0]   rd_sel = '0;
    logic [11:0]       rd_bcd;

    bcd_conv_sched #(.CH(CH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .value     (value),
        .grant     (grant),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .rd_sel    (rd_sel),
        .rd_bcd    (rd_bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [11:0] bcd;
    } exp_t;

    exp_t        q[$];
    exp_t        m_cur;
    logic [11:0] m_bank [CH];
    logic [11:0] m_hold_bcd = '0;
    int          m_hold_ch = 0;
    logic [CH-1:0] m_grant = '0;
    bit          m_busy = 0;
    bit          m_valid = 0;
    int          m_cnt = 0;
    int          m_ptr = CH - 1;
    int          errors = 0;
    int          checks = 0;
    bit          rd_lock = 0;
    logic [CH_W-1:0] rd_fix = '0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one conversion occupies the engine for 9 edges,
    // round-robin search from the last winner, digits by plain arithmetic.
    initial begin
        for (int i = 0; i < CH; i++) m_bank[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_grant = '0; m_busy = 0; m_valid = 0; m_cnt = 0; m_ptr = CH - 1;
                m_hold_bcd = '0; m_hold_ch = 0;
                q.delete();
                for (int i = 0; i < CH; i++) m_bank[i] = '0;
            end else begin
                m_grant = '0;
                m_valid = 0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 0;
                        m_valid = 1;
                        m_bank[m_cur.ch] = m_cur.bcd;
                        m_hold_bcd = m_cur.bcd;
                        m_hold_ch = m_cur.ch;
                    end
                end else if (|req) begin
                    for (int k = 1; k <= CH; k++) begin
                        int c;
                        c = (m_ptr + k) % CH;
                        if (req[c]) begin
                            m_grant[c] = 1'b1;
                            m_ptr = c;
                            m_cur.ch = c;
                            m_cur.bcd = to_bcd(int'(value[8*c +: 8]));
                            q.push_back(m_cur);
                            m_busy = 1;
                            m_cnt = 8;
                            break;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares DUT against model away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("grant", 32'(grant), 32'(m_grant));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("held_digits", {20'd0, hundreds, tens, ones}, {20'd0, m_hold_bcd});
            chk("held_ch", 32'(out_ch), 32'(m_hold_ch));
            chk("rd_bcd", 32'(rd_bcd), 32'(m_bank[rd_sel]));
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("result_ch", 32'(out_ch), 32'(e.ch));
                    chk("result_bcd", {20'd0, hundreds, tens, ones}, {20'd0, e.bcd});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_sel = rd_lock ? rd_fix : CH_W'($urandom_range(0, CH - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_val(input int ch, input int v);
        value[8*ch +: 8] = 8'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    int sweep [6] = '{0, 9, 10, 99, 100, 128};

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // 255 on ch0 for one sample
        set_val(0, 255); req = 4'b0001;
        tick(1); req = '0;
        tick(10);

        // held request on ch2, operand changed after each grant
        set_val(2, sweep[0]); req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (i < 5) set_val(2, sweep[i + 1]);
            tick(8);
        end
        req = '0;
        tick(3);

        // all channels continuously
        do_reset();
        set_val(0, 11); set_val(1, 22); set_val(2, 33); set_val(3, 44);
        req = 4'b1111;
        tick(45);
        req = '0;
        tick(12);
        for (int i = 0; i < CH; i++) begin
            rd_lock = 1; rd_fix = CH_W'(i);
            tick(1);
        end
        rd_lock = 0;

        // wrap past the pointer, late request while busy; watch ch3 bank write
        do_reset();
        set_val(1, 7); req = 4'b0010;
        tick(1); req = '0;
        tick(9);
        set_val(0, 63); set_val(3, 181); req = 4'b0011;
        tick(1);
        req = 4'b1001;
        rd_lock = 1; rd_fix = 2'd3;
        tick(9);
        req = '0;
        tick(10);
        rd_lock = 0;

        // reset during a conversion, then resubmit
        set_val(1, 200); req = 4'b0010;
        tick(1); req = '0;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        req = 4'b0010;
        tick(1); req = '0;
        tick(10);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            value = $urandom();
            req = ($urandom_range(0, 3) == 0) ? '0 : CH'($urandom_range(0, 15));
            tick(1);
        end
        req = '0;
        tick(12);

        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
Shared iterative binary-to-BCD conversion engine with a round-robin scheduler for CH requesters. Each requester presents an 8-bit binary value. The block grants one requester at a time and converts the value with 8 shift-add-3 steps, one per clock. It publishes the hundreds/tens/ones result with a valid strobe and the channel id, and keeps the latest result per channel in a readable result bank. It replaces per-channel combinational converters in front of the 7-segment display path.

Parameters:
CH, 4, number of requesting channels (2..8).
CH_W, 2, channel-id width; must equal ceil(log2(CH)).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  CH  per-channel conversion request (level).
value  input  8*CH  packed binary operands; channel i occupies bits [8*i+7 : 8*i].
grant  output  CH  one-hot, one-cycle pulse: value of that channel has been captured.
busy  output  1  high while a conversion is in progress.
out_valid  output  1  one-cycle pulse: result outputs updated.
out_ch  output  CH_W  channel id of the current result.
hundreds  output  4  BCD hundreds digit (0..2).
tens  output  4  BCD tens digit (0..9).
ones  output  4  BCD ones digit (0..9).
rd_sel  input  CH_W  result-bank read select.
rd_bcd  output  12  result bank entry for rd_sel, {hundreds,tens,ones}; combinational read.

Behaviour:
- Reset (rst_n low, asynchronous) clears all of the following:
  - state = IDLE, grant = 0, busy = 0, out_valid = 0, out_ch = 0.
  - hundreds/tens/ones = 0, all bank entries = 0.
  - step counter = 0, round-robin pointer = CH-1, so channel 0 has first priority.
- FSM states:
  - IDLE: if any req bit is high at edge E, arbitrate, load value[granted] into the 8-bit binary part of a 20-bit shift register (BCD part zeroed), set step counter = 8, and go to CONV. grant[i] is high for the cycle after E. busy goes high after E. With no request, stay in IDLE.
  - CONV: each edge performs one double-dabble step:
    - for each 4-bit BCD digit >= 5, add 3, with no carry between digits;
    - then shift the 20-bit register left by 1;
    - then decrement the counter.
  - CONV exit: on the edge where the counter goes 1->0, register the final digits into hundreds/tens/ones, set out_ch, write the bank entry for that channel, pulse out_valid for one cycle, clear busy, and return to IDLE.
- Latency and throughput:
  - req sampled at edge E -> out_valid high during the cycle after edge E+8 (9 edges total).
  - A new request may be accepted at edge E+9, giving one conversion per 9 cycles.
  - There is no idle gap beyond that.
- Arbitration (round-robin):
  - Search starts at pointer+1 modulo CH; the first high req wins.
  - The pointer updates to the winner at the grant edge.
  - req is ignored while busy.
- Requester protocol:
  - Holding req high after grant causes a further conversion when that channel's turn returns.
  - value must be stable only at the sampling edge.
  - A req dropped before being granted is simply never served; there is no error indication.
- Outputs hundreds/tens/ones/out_ch hold their last value until the next out_valid.
- Bank write and rd_bcd read of the same entry in one cycle: rd_bcd shows the old value until the edge, the new value after it.
- rd_sel >= CH returns 12'h000.
- Reset asserted mid-conversion aborts immediately to reset values. No out_valid is produced, and the bank is cleared.
- Width rules: the maximum input 255 yields hundreds = 2, so the hundreds digit never exceeds 4'd2. All add-3 operations are 4-bit with no overflow.

Test Plan:
- Reset, then req[0]=1 with value0=8'd255 held for 1 cycle -> grant = 4'b0001 one cycle after sampling; 9 edges later out_valid=1, out_ch=0, hundreds/tens/ones = 2/5/5; rd_sel=0 gives 12'h255.
- Single-channel sweep on ch2 of 0, 9, 10, 99, 100, 128 -> 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 1/2/8; one out_valid per conversion, spaced exactly 9 cycles apart with req held.
- All four req high continuously after reset, with values 11/22/33/44 -> grants in order ch0, ch1, ch2, ch3, ch0; out_ch sequence 0,1,2,3; bank reads 12'h011, 12'h022, 12'h033, 12'h044.
- Pointer at ch1 (last granted), req = 4'b0011 -> next grant ch0 (wrap past ch2/ch3). Then req[3] rises while busy -> ignored until IDLE, then granted ahead of ch0/ch1.
- rst_n pulled low 4 cycles into a conversion of 8'd200 -> outputs and bank go to zero immediately, no out_valid; after release, req resubmitted -> 2/0/0 with normal 9-edge latency.
- rd_sel = 3 while the ch3 result is written -> rd_bcd shows the old entry that cycle and the new entry the next cycle.
